delay_monitor: RTL and testbench

Clocked observer that sits at the far end of a delayed signal path: it watches a stimulus net and the response of the delaying element and measures propagation delay in clock cycles. It also flags input pulses the element swallowed (inertial filtering), responses that never arrive, and spurious response edges. It is used in benches and bring-up logic as the measurement counterpart to our delay and gate elements.

---
 rtl/delay_mon_pkg.sv | 14 +
 rtl/delay_mon_edge_det.sv | 23 ++
 rtl/delay_monitor.sv | 159 +++++++++++++++
 tb/tb_delay_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_mon_pkg.sv
// Shared types and default constants for the delay monitor.
// The optional min/max tracker is built only when DELAY_MON_MINMAX_EN is defined.
package delay_mon_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int DM_CNT_W   = 8;
   localparam int DM_TIMEOUT = 200;
   localparam int DM_SCNT_W  = 16;

endpackage

// File: rtl/delay_mon_edge_det.sv
// Single-bit change detector. The previous value keeps tracking through clear,
// but a change seen during clear is suppressed.
module edge_det (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic sig,
   output logic change
);

   logic prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev <= 1'b0;
      end else begin
         prev <= sig;
      end
   end

   assign change = (sig != prev) && !clear;

endmodule

// File: rtl/delay_monitor.sv
// Measures stimulus-to-response delay in cycles and flags swallowed pulses,
// timeouts and spurious response edges. Optional min/max via DELAY_MON_MINMAX_EN.
module delay_monitor
   import delay_mon_pkg::*;
#(
   parameter int CNT_W   = DM_CNT_W,
   parameter int TIMEOUT = DM_TIMEOUT
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 stim_in,
   input  logic                 resp_in,
   input  logic                 clear,
   output logic                 meas_valid,
   output logic [CNT_W-1:0]     meas_delay,
   output logic                 swallowed,
   output logic                 timeout_err,
   output logic                 spurious_err,
   output logic [DM_SCNT_W-1:0] sample_count,
   output logic [CNT_W-1:0]     min_delay,
   output logic [CNT_W-1:0]     max_delay
);

   logic stim_edge;
   logic resp_edge;

   edge_det u_stim_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .sig     (stim_in),
      .change  (stim_edge)
   );

   edge_det u_resp_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .sig     (resp_in),
      .change  (resp_edge)
   );

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             target, target_next;
   logic             meas_fire, swallow_fire, timeout_fire, spurious_fire;
   logic [CNT_W-1:0] meas_value;

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      target_next   = target;
      meas_fire     = 1'b0;
      meas_value    = cnt;
      swallow_fire  = 1'b0;
      timeout_fire  = 1'b0;
      spurious_fire = 1'b0;
      case (state)
         IDLE: begin
            if (stim_edge && resp_edge && (resp_in == stim_in)) begin
               meas_fire  = 1'b1;
               meas_value = '0;
            end else begin
               if (stim_edge) begin
                  target_next = stim_in;
                  cnt_next    = CNT_W'(1);
                  state_next  = WAIT;
               end
               if (resp_edge) spurious_fire = 1'b1;
            end
         end
         WAIT: begin
            if (resp_edge && (resp_in != target)) spurious_fire = 1'b1;
            if (resp_edge && (resp_in == target)) begin
               meas_fire  = 1'b1;
               meas_value = cnt;
               // A new stimulus edge coinciding with the response starts the next measurement
               if (stim_edge) begin
                  target_next = stim_in;
                  cnt_next    = CNT_W'(1);
               end else begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end else if (stim_edge) begin
               swallow_fire = 1'b1;
               state_next   = IDLE;
               cnt_next     = '0;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
               timeout_fire = 1'b1;
               state_next   = IDLE;
               cnt_next     = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         target       <= 1'b0;
         meas_valid   <= 1'b0;
         meas_delay   <= '0;
         swallowed    <= 1'b0;
         timeout_err  <= 1'b0;
         spurious_err <= 1'b0;
         sample_count <= '0;
      end else if (clear) begin
         state        <= IDLE;
         cnt          <= '0;
         target       <= 1'b0;
         meas_valid   <= 1'b0;
         swallowed    <= 1'b0;
         timeout_err  <= 1'b0;
         spurious_err <= 1'b0;
         sample_count <= '0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         target       <= target_next;
         meas_valid   <= meas_fire;
         swallowed    <= swallow_fire;
         timeout_err  <= timeout_fire;
         spurious_err <= spurious_fire;
         if (meas_fire) begin
            meas_delay <= meas_value;
            if (sample_count != '1) sample_count <= sample_count + DM_SCNT_W'(1);
         end
      end
   end

`ifdef DELAY_MON_MINMAX_EN
   logic [CNT_W-1:0] min_val, max_val;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         min_val <= '1;
         max_val <= '0;
      end else if (clear) begin
         min_val <= '1;
         max_val <= '0;
      end else if (meas_fire) begin
         if (meas_value < min_val) min_val <= meas_value;
         if (meas_value > max_val) max_val <= meas_value;
      end
   end

   assign min_delay = min_val;
   assign max_delay = max_val;
`else
   assign min_delay = '1;
   assign max_delay = '0;
`endif

endmodule

// File: tb/tb_delay_monitor.sv
// Directed self-checking bench for delay_monitor (CNT_W = 8, TIMEOUT = 200);
// min/max expectations follow DELAY_MON_MINMAX_EN.
module tb_delay_monitor;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stim_in;
   logic        resp_in;
   logic        clear;
   logic        meas_valid;
   logic [7:0]  meas_delay;
   logic        swallowed;
   logic        timeout_err;
   logic        spurious_err;
   logic [15:0] sample_count;
   logic [7:0]  min_delay;
   logic [7:0]  max_delay;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DELAY_MON_MINMAX_EN
   localparam logic [7:0] EXP_MIN = 8'd4;
   localparam logic [7:0] EXP_MAX = 8'd10;
`else
   localparam logic [7:0] EXP_MIN = 8'hFF;
   localparam logic [7:0] EXP_MAX = 8'h00;
`endif

   always #5 clock = ~clock;

   delay_monitor #(.CNT_W(8), .TIMEOUT(200)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .stim_in      (stim_in),
      .resp_in      (resp_in),
      .clear        (clear),
      .meas_valid   (meas_valid),
      .meas_delay   (meas_delay),
      .swallowed    (swallowed),
      .timeout_err  (timeout_err),
      .spurious_err (spurious_err),
      .sample_count (sample_count),
      .min_delay    (min_delay),
      .max_delay    (max_delay)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; stim_in = 1'b0; resp_in = 1'b0; clear = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({meas_valid, swallowed, timeout_err, spurious_err} !== 4'b0) begin
         $display("FAIL reset_pulses got=%b want=0000", {meas_valid, swallowed, timeout_err, spurious_err}); n_bad++;
      end
      n_cmp++;
      if (meas_delay !== 8'd0 || sample_count !== 16'd0) begin
         $display("FAIL reset_meas got delay=%0d count=%0d want 0/0", meas_delay, sample_count); n_bad++;
      end
      n_cmp++;
      if (min_delay !== 8'hFF || max_delay !== 8'h00) begin
         $display("FAIL reset_minmax got min=%h max=%h want ff/00", min_delay, max_delay); n_bad++;
      end
      reset_n = 1'b1;
      repeat (2) tick();
      $display("reset: done");
   endtask

   task automatic test_delay();
      stim_in = 1'b1;
      tick();
      repeat (9) tick();
      n_cmp++;
      if (meas_valid !== 1'b0) begin
         $display("FAIL delay_early got meas_valid=%b want 0", meas_valid); n_bad++;
      end
      resp_in = 1'b1;
      tick();
      n_cmp++;
      if (meas_valid !== 1'b1 || meas_delay !== 8'd10 || sample_count !== 16'd1) begin
         $display("FAIL delay_meas got valid=%b delay=%0d count=%0d want 1/10/1", meas_valid, meas_delay, sample_count); n_bad++;
      end
      tick();
      n_cmp++;
      if (meas_valid !== 1'b0) begin
         $display("FAIL delay_pulse_len got meas_valid=%b want 0", meas_valid); n_bad++;
      end
      $display("delay: delay=%0d count=%0d", meas_delay, sample_count);
   endtask

   task automatic test_swallow();
      logic seen = 1'b0;
      stim_in = 1'b0;
      tick();
      repeat (4) begin
         tick();
         if (meas_valid || swallowed) seen = 1'b1;
      end
      stim_in = 1'b1;
      tick();
      n_cmp++;
      if (seen !== 1'b0) begin
         $display("FAIL swallow_early got early_pulse=%b want 0", seen); n_bad++;
      end
      n_cmp++;
      if (swallowed !== 1'b1 || meas_valid !== 1'b0) begin
         $display("FAIL swallow_pulse got swallowed=%b valid=%b want 1/0", swallowed, meas_valid); n_bad++;
      end
      tick();
      n_cmp++;
      if (swallowed !== 1'b0 || sample_count !== 16'd1) begin
         $display("FAIL swallow_after got swallowed=%b count=%0d want 0/1", swallowed, sample_count); n_bad++;
      end
      $display("swallow: done");
   endtask

   task automatic test_timeout();
      logic seen = 1'b0;
      stim_in = 1'b0;
      tick();
      repeat (199) begin
         tick();
         if (timeout_err || meas_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         $display("FAIL timeout_early got early_pulse=%b want 0", seen); n_bad++;
      end
      tick();
      n_cmp++;
      if (timeout_err !== 1'b1) begin
         $display("FAIL timeout_pulse got timeout_err=%b want 1", timeout_err); n_bad++;
      end
      tick();
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         $display("FAIL timeout_len got timeout_err=%b want 0", timeout_err); n_bad++;
      end
      $display("timeout: done");
   endtask

   task automatic test_spurious_zero();
      resp_in = 1'b0;
      tick();
      n_cmp++;
      if (spurious_err !== 1'b1) begin
         $display("FAIL spurious_idle got spurious_err=%b want 1", spurious_err); n_bad++;
      end
      tick();
      n_cmp++;
      if (spurious_err !== 1'b0) begin
         $display("FAIL spurious_len got spurious_err=%b want 0", spurious_err); n_bad++;
      end
      stim_in = 1'b1; resp_in = 1'b1;
      tick();
      n_cmp++;
      if (meas_valid !== 1'b1 || meas_delay !== 8'd0 || sample_count !== 16'd2) begin
         $display("FAIL zero_delay got valid=%b delay=%0d count=%0d want 1/0/2", meas_valid, meas_delay, sample_count); n_bad++;
      end
      tick();
      $display("spurious_zero: delay=%0d count=%0d", meas_delay, sample_count);
   endtask

   task automatic test_minmax_clear();
      int dl[3] = '{10, 4, 7};
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_cmp++;
      if (sample_count !== 16'd0 || min_delay !== 8'hFF || max_delay !== 8'h00) begin
         $display("FAIL clear_first got count=%0d min=%h max=%h want 0/ff/00", sample_count, min_delay, max_delay); n_bad++;
      end
      foreach (dl[i]) begin
         stim_in = ~stim_in;
         tick();
         repeat (dl[i] - 1) tick();
         resp_in = ~resp_in;
         tick();
         n_cmp++;
         if (meas_valid !== 1'b1 || meas_delay !== 8'(dl[i])) begin
            $display("FAIL minmax_meas%0d got valid=%b delay=%0d want 1/%0d", i, meas_valid, meas_delay, dl[i]); n_bad++;
         end
         tick();
      end
      n_cmp++;
      if (sample_count !== 16'd3 || min_delay !== EXP_MIN || max_delay !== EXP_MAX) begin
         $display("FAIL minmax got count=%0d min=%0d max=%0d want 3/%0d/%0d", sample_count, min_delay, max_delay, EXP_MIN, EXP_MAX); n_bad++;
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_cmp++;
      if (sample_count !== 16'd0 || min_delay !== 8'hFF || max_delay !== 8'h00 || meas_delay !== 8'd7) begin
         $display("FAIL clear got count=%0d min=%h max=%h delay=%0d want 0/ff/00/7", sample_count, min_delay, max_delay, meas_delay); n_bad++;
      end
      $display("minmax_clear: done");
   endtask

   task automatic test_back_to_back();
      stim_in = 1'b1;
      tick();
      repeat (2) tick();
      resp_in = 1'b1; stim_in = 1'b0;
      tick();
      n_cmp++;
      if (meas_valid !== 1'b1 || meas_delay !== 8'd3) begin
         $display("FAIL b2b_first got valid=%b delay=%0d want 1/3", meas_valid, meas_delay); n_bad++;
      end
      repeat (4) tick();
      resp_in = 1'b0;
      tick();
      n_cmp++;
      if (meas_valid !== 1'b1 || meas_delay !== 8'd5 || sample_count !== 16'd2) begin
         $display("FAIL b2b_second got valid=%b delay=%0d count=%0d want 1/5/2", meas_valid, meas_delay, sample_count); n_bad++;
      end
      tick();
      $display("back_to_back: done");
   endtask

   task automatic test_reset_abort();
      logic seen = 1'b0;
      stim_in = 1'b1;
      tick();
      repeat (2) tick();
      reset_n = 1'b0; stim_in = 1'b0;
      #1;
      n_cmp++;
      if (meas_delay !== 8'd0 || sample_count !== 16'd0 || min_delay !== 8'hFF || max_delay !== 8'h00 ||
          {meas_valid, swallowed, timeout_err, spurious_err} !== 4'b0) begin
         $display("FAIL abort_reset got delay=%0d count=%0d min=%h max=%h want 0/0/ff/00", meas_delay, sample_count, min_delay, max_delay); n_bad++;
      end
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (250) begin
         tick();
         if (meas_valid || swallowed || timeout_err) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         $display("FAIL abort_quiet got stray_pulse=%b want 0", seen); n_bad++;
      end
      $display("reset_abort: done");
   endtask

   initial begin
      test_reset();
      test_delay();
      test_swallow();
      test_timeout();
      test_spurious_zero();
      test_minmax_clear();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
